// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - N-channel cache-line arbiter with integrated line/burst adaptor
//
// Purpose: grants one cache line read or writeback at a time to a single burst memory
// port, splitting a LINE_W line into LINE_W/BURST_W beats (beat 0 = LSBs) on writes and
// assembling beats into ch_rdata on reads. Arbitration is round-robin by default; with
// LINE_ARB_FIXED_PRIO_EN defined the lowest-index requesting channel always wins.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   ch_read/ch_write        per-channel line requests (write wins if both set)
//   ch_address/ch_wdata     per-channel address and writeback line, channel i = slice i
//   ch_rdata                shared read line, valid when the owner's ch_resp pulses
//   ch_resp                 one-cycle completion pulse to the granted channel
//   pmem_read/pmem_write    burst direction, held for the whole burst
//   pmem_address            line-aligned burst address
//   pmem_wdata/pmem_rdata   current write / read beat
//   pmem_resp               one beat accepted/delivered this cycle
module line_mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [BURST_W-1:0]         pmem_wdata,
  input  logic [BURST_W-1:0]         pmem_rdata,
  input  logic                       pmem_resp
);

  localparam int BEATS  = LINE_W / BURST_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;

  logic [NUM_CH-1:0]   req;
  logic                found;
  logic [CH_W-1:0]     win;
  logic                last_beat;
  int                  idx;

  assign req       = ch_read | ch_write;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Rotating search: first requester at or after ptr, wrapping modulo NUM_CH.
  // In fixed-priority builds ptr stays 0, so this degenerates to lowest index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr_q) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          addr_d  = ch_address[int'(win)*ADDR_W +: ADDR_W] & ALIGN_MASK;
          state_d = ch_write[win] ? WR : RD;
        end
      end
      RD: begin
        if (pmem_resp) begin
          rdata_d[int'(beat_q)*BURST_W +: BURST_W] = pmem_rdata;
          beat_d = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WR: begin
        if (pmem_resp) begin
          beat_d = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef LINE_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = CH_W'((int'(grant_q) + 1) % NUM_CH);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them immediately.
  assign pmem_read    = (state_q == RD);
  assign pmem_write   = (state_q == WR);
  assign pmem_address = addr_q;
  assign ch_rdata     = rdata_q;
  // Write beats are taken live from the winner's slice; the channel holds wdata stable.
  assign pmem_wdata   = (state_q == WR)
                      ? ch_wdata[int'(grant_q)*LINE_W + int'(beat_q)*BURST_W +: BURST_W]
                      : '0;

  always_comb begin
    ch_resp = '0;
    if (state_q == DONE) ch_resp[grant_q] = 1'b1;
  end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb/tb_line_mem_arbiter.sv - self-checking bench for line_mem_arbiter
module tb_line_mem_arbiter;
  localparam int N = 2, LW = 256, BW = 64, AW = 32, BEATS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N-1:0]      ch_read, ch_write, ch_resp;
  logic [N*AW-1:0]   ch_address;
  logic [N*LW-1:0]   ch_wdata;
  logic [LW-1:0]     ch_rdata;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0]     pmem_address;
  logic [BW-1:0]     pmem_wdata, pmem_rdata;

  line_mem_arbiter #(.NUM_CH(N), .LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_resp(ch_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp));

  logic [3:0]    d4_read, d4_write, d4_resp;
  logic [127:0]  d4_addr, d4_pwdata, d4_prdata;
  logic [2047:0] d4_wdata;
  logic [511:0]  d4_rdata;
  logic          d4_prd, d4_pwr, d4_presp;
  logic [31:0]   d4_paddr;

  line_mem_arbiter #(.NUM_CH(4), .LINE_W(512), .BURST_W(128), .ADDR_W(32)) dut4 (
    .clk(clk), .reset_n(reset_n), .ch_read(d4_read), .ch_write(d4_write),
    .ch_address(d4_addr), .ch_wdata(d4_wdata), .ch_rdata(d4_rdata), .ch_resp(d4_resp),
    .pmem_read(d4_prd), .pmem_write(d4_pwr), .pmem_address(d4_paddr),
    .pmem_wdata(d4_pwdata), .pmem_rdata(d4_prdata), .pmem_resp(d4_presp));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: transaction phases 0=idle 1=burst 2=completion 3=post-completion idle.
  int m_phase = 0, m_ptr = 0, m_win = 0, m_beats = 0, wait_cnt = 0, mem_mode = 0;
  int cyc = 0, resp_cnt = 0, resp_cyc = 0, wr_high = 0;
  int waited[N];
  int grant_q[$];
  bit op_q[$];
  bit m_wr, auto_req = 0, hold_req = 0;
  logic [AW-1:0] m_addr, first_addr;
  logic [LW-1:0] m_line;

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] req;
    int w, t;
    bit r;
    @(negedge clk);
    cyc++;
    req = ch_read | ch_write;
    if (m_phase == 3) begin
      check("gap_pmem", {pmem_read, pmem_write}, 0);
      check("gap_resp", ch_resp, 0);
      m_phase = 0;
      pmem_resp = 1'($urandom_range(0, 1));
    end else if (m_phase == 2) begin
      check("done_resp", ch_resp, N'(1) << m_win);
      check("done_pmem", {pmem_read, pmem_write}, 0);
      if (!m_wr) check("done_rdata", ch_rdata, m_line);
      resp_cnt++;
      resp_cyc = cyc;
`ifdef LINE_ARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (m_win + 1) % N;
`endif
      if (m_wr && ch_read[m_win]) ch_write[m_win] = 1'b0;
      else if (!hold_req) begin
        ch_read[m_win] = 1'b0;
        ch_write[m_win] = 1'b0;
      end
      m_phase = 3;
      pmem_resp = 1'($urandom_range(0, 1));
    end else begin
      if (m_phase == 0) begin
        if (req != 0) begin
          w = pick(req, m_ptr);
          m_win = w;
          m_wr = ch_write[w];
          m_addr = ch_address[w*AW +: AW] & 32'hFFFF_FFE0;
          m_line = m_wr ? ch_wdata[w*LW +: LW] : '0;
          first_addr = pmem_address;
          check("start_rd", pmem_read, !m_wr);
          check("start_wr", pmem_write, m_wr);
`ifndef LINE_ARB_FIXED_PRIO_EN
          for (int i = 0; i < N; i++) begin
            if (i == w || !req[i]) waited[i] = 0;
            else begin
              waited[i]++;
              check("rr_wait_bound", waited[i] <= N - 1, 1);
            end
          end
`endif
          grant_q.push_back(w);
          op_q.push_back(m_wr);
          m_beats = 0;
          wait_cnt = 0;
          m_phase = 1;
        end else begin
          check("idle_pmem", {pmem_read, pmem_write}, 0);
          check("idle_resp", ch_resp, 0);
          pmem_resp = 1'($urandom_range(0, 1));
        end
      end
      if (m_phase == 1) begin
        check("burst_rd", pmem_read, !m_wr);
        check("burst_wr", pmem_write, m_wr);
        check("burst_addr", pmem_address, m_addr);
        check("burst_resp", ch_resp, 0);
        if (m_wr) begin
          wr_high++;
          check("wdata", pmem_wdata, m_line[m_beats*BW +: BW]);
        end
        if (mem_mode < 0) r = ($urandom_range(0, 2) != 0);
        else begin
          r = (wait_cnt == mem_mode);
          wait_cnt = r ? 0 : wait_cnt + 1;
        end
        pmem_rdata = (mem_mode < 0) ? {$urandom, $urandom}
                                    : 64'h1111_1111_1111_1111 * (m_beats + 1);
        pmem_resp = r;
        if (r) begin
          if (!m_wr) m_line[m_beats*BW +: BW] = pmem_rdata;
          m_beats++;
          if (m_beats == BEATS) m_phase = 2;
        end
      end
    end
    if (auto_req) begin
      for (int i = 0; i < N; i++) begin
        if (!ch_read[i] && !ch_write[i] && $urandom_range(0, 2) == 0) begin
          t = $urandom_range(0, 2);
          ch_read[i] = (t != 1);
          ch_write[i] = (t != 0);
          ch_address[i*AW +: AW] = $urandom;
          ch_wdata[i*LW +: LW] = {8{$urandom}};
        end
      end
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (((ch_read | ch_write) != 0 || m_phase != 0) && n < max) begin
      step();
      n++;
    end
    check("drain_in_budget", n < max, 1);
  endtask

  int exp4[4];
  int t0, r0, n;
  int d4_cnt, d4_rd_cycles;
  logic [3:0] d4_resps[$];
  logic [31:0] d4_addrs[$];
  logic d4_prev;
  bit seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LINE_ARB_FIXED_PRIO_EN
    exp4 = '{0, 0, 0, 0};
`else
    exp4 = '{0, 1, 0, 1};
`endif
    reset_n = 1'b1;
    ch_read = '0; ch_write = '0; ch_address = '0; ch_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    d4_read = '0; d4_write = '0; d4_addr = '0; d4_wdata = '0; d4_prdata = '0; d4_presp = 1'b0;
    for (int i = 0; i < N; i++) waited[i] = 0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_pmem", {pmem_read, pmem_write}, 0);
    check("rst_addr", pmem_address, 0);
    check("rst_rdata", ch_rdata, 0);
    check("rst_resp", ch_resp, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted mid read burst at beat 2
    ch_read = 2'b01;
    ch_address[31:0] = 32'h0000_0040;
    mem_mode = 0;
    n = 0;
    while (m_beats < 2 && n < 20) begin step(); n++; end
    check("t1_reached_beat2", m_beats >= 2, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t1_pmem", {pmem_read, pmem_write}, 0);
    check("t1_addr", pmem_address, 0);
    check("t1_wdata", pmem_wdata, 0);
    check("t1_rdata", ch_rdata, 0);
    check("t1_resp", ch_resp, 0);
    ch_read = '0; ch_write = '0; pmem_resp = 1'b0;
    m_phase = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) waited[i] = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // Single read, zero-wait beats
    ch_read = 2'b01;
    ch_address[31:0] = 32'h0000_1234;
    t0 = cyc;
    drain(50);
    check("t2_addr", first_addr, 32'h0000_1220);
    check("t2_resp_cycle", resp_cyc - t0 + 1, 6);
    check("t2_rdata", ch_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Channel 1 writeback with two wait cycles per beat
    ch_write = 2'b10;
    ch_address[63:32] = 32'h0000_2000;
    ch_wdata[511:256] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mem_mode = 2; wr_high = 0; r0 = resp_cnt;
    drain(100);
    check("t3_write_cycles", wr_high, 12);
    check("t3_resps", resp_cnt - r0, 1);

    // Both channels holding read continuously
    mem_mode = 0;
    ch_read = 2'b11;
    grant_q.delete();
    hold_req = 1;
    n = 0;
    while (grant_q.size() < 4 && n < 200) begin step(); n++; end
    hold_req = 0;
    drain(200);
    check("t4_grants", grant_q.size() >= 4, 1);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_grant%0d", k), (k < grant_q.size()) ? grant_q[k] : -1, exp4[k]);

    // Read and write together on one channel
    op_q.delete();
    r0 = resp_cnt;
    ch_read[0] = 1'b1; ch_write[0] = 1'b1;
    ch_address[31:0] = 32'h0000_8040;
    ch_wdata[255:0] = {8{32'hA5A5_0001}};
    drain(100);
    check("t5_resps", resp_cnt - r0, 2);
    check("t5_first_is_write", (op_q.size() > 0) ? op_q[0] : 1'b0, 1);
    check("t5_second_is_read", (op_q.size() > 1) ? op_q[1] : 1'b1, 0);

    // Randomized traffic
    auto_req = 1; mem_mode = -1;
    repeat (600) step();
    auto_req = 0;
    drain(300);

    // Four-channel wide configuration
    d4_read = 4'b1010;
    d4_addr[32 +: 32] = 32'h0000_0100;
    d4_addr[96 +: 32] = 32'h0000_0300;
    d4_cnt = 0; d4_rd_cycles = 0; d4_prev = 1'b0;
    for (int c = 0; c < 60 && d4_resps.size() < 2; c++) begin
      @(negedge clk);
      if (d4_prd && !d4_prev) d4_addrs.push_back(d4_paddr);
      d4_prev = d4_prd;
      if (d4_prd) begin
        d4_rd_cycles++;
        d4_prdata = 128'(d4_cnt + 1);
        d4_presp = 1'b1;
        d4_cnt++;
      end else d4_presp = 1'b0;
      if (d4_resp != 0) begin
        d4_resps.push_back(d4_resp);
        d4_read = d4_read & ~d4_resp;
      end
    end
    check("t6_resp_count", d4_resps.size(), 2);
    check("t6_resp0", (d4_resps.size() > 0) ? d4_resps[0] : 4'h0, 4'b0010);
    check("t6_resp1", (d4_resps.size() > 1) ? d4_resps[1] : 4'h0, 4'b1000);
    check("t6_addr0", (d4_addrs.size() > 0) ? d4_addrs[0] : 32'hFFFF_FFFF, 32'h0000_0100);
    check("t6_addr1", (d4_addrs.size() > 1) ? d4_addrs[1] : 32'hFFFF_FFFF, 32'h0000_0300);
    check("t6_read_cycles", d4_rd_cycles, 8);
    check("t6_rdata", d4_rdata, {128'd8, 128'd7, 128'd6, 128'd5});
    d4_read = 4'b1010;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (d4_prd) seen = 1;
    end
    check("t6_ptr_wrapped", seen ? d4_paddr : 32'hFFFF_FFFF, 32'h0000_0100);
    d4_read = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
